press_classifier: RTL and testbench

Downstream consumer of the switch-detect stage. Takes its one-cycle `detected` pulse plus the synchronized switch level and classifies each user gesture as a single click, a double click or a long press. Each classification is emitted as a one-cycle event pulse for the control logic on the PCB. Runs on the 5 MHz (200 ns) system clock.

---
 rtl/press_classifier.sv | 117 +++++++++++
 tb/tb_press_classifier.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// Classifies switch gestures into single click, double click and long press event pulses.
// Optional PRESS_COUNT_EN adds an 8-bit wrapping count of classified events.
module press_classifier #(
  parameter int unsigned LONG_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES  = 1500000,
  parameter int unsigned CNT_W       = 23
) (
  input  logic CLK,
  input  logic RST,
  input  logic detected,
  input  logic switch_level,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0] event_count
`endif
);

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StWaitGap,
    StPress2,
    StHoldLong
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             busy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (detected) state_d = StPress1;
      end
      StPress1: begin
        if (!switch_level) begin
          state_d = StWaitGap;
        end else if (cnt_q == LongLast) begin
          long_d  = 1'b1;
          state_d = StHoldLong;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitGap: begin
        // A second press on the timeout cycle still counts as a double click.
        if (detected) begin
          double_d = 1'b1;
          state_d  = StPress2;
        end else if (cnt_q == GapLast) begin
          single_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPress2, StHoldLong: begin
        if (!switch_level) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign busy         = busy_q;

`ifdef PRESS_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= 8'd0;
    end else if (single_d || double_d || long_d) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign event_count = count_q;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Randomized and directed bench for press_classifier against a gesture-level reference model.
module tb_press_classifier;

  localparam int unsigned Long = 20;
  localparam int unsigned Gap  = 10;

  localparam int MIdle     = 0;
  localparam int MHeld     = 1;
  localparam int MGap      = 2;
  localparam int MSecond   = 3;
  localparam int MLongHeld = 4;

  logic CLK = 1'b0;
  logic RST;
  logic detected;
  logic switch_level;
  logic single_click, double_click, long_press, busy;
`ifdef PRESS_COUNT_EN
  logic [7:0] event_count;
`endif

  always #5 CLK = ~CLK;

  press_classifier #(
    .LONG_CYCLES(Long),
    .GAP_CYCLES (Gap),
    .CNT_W      (5)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .detected    (detected),
    .switch_level(switch_level),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .busy        (busy)
`ifdef PRESS_COUNT_EN
    ,
    .event_count (event_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: gesture phase plus the edge index at which the phase began.
  int mode     = MIdle;
  int t_enter  = 0;
  int edge_n   = 0;
  int m_single = 0;
  int m_double = 0;
  int m_long   = 0;
  int m_count  = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode     = MIdle;
    m_single = 0;
    m_double = 0;
    m_long   = 0;
    m_count  = 0;
  endtask

  task automatic model_step();
    edge_n++;
    m_single = 0;
    m_double = 0;
    m_long   = 0;
    case (mode)
      MIdle: if (detected) begin
        mode    = MHeld;
        t_enter = edge_n;
      end
      MHeld: if (!switch_level) begin
        mode    = MGap;
        t_enter = edge_n;
      end else if (edge_n - t_enter == int'(Long)) begin
        m_long = 1;
        mode   = MLongHeld;
      end
      MGap: if (detected) begin
        m_double = 1;
        mode     = MSecond;
      end else if (edge_n - t_enter == int'(Gap)) begin
        m_single = 1;
        mode     = MIdle;
      end
      default: if (!switch_level) mode = MIdle;
    endcase
    if (m_single + m_double + m_long != 0) m_count = (m_count + 1) % 256;
  endtask

  // One clock: model follows the sampled inputs, outputs compared on the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (!RST) model_step();
    @(negedge CLK);
    check_eq("single_click", int'(single_click), m_single);
    check_eq("double_click", int'(double_click), m_double);
    check_eq("long_press", int'(long_press), m_long);
    check_eq("busy", int'(busy), (mode != MIdle) ? 1 : 0);
`ifdef PRESS_COUNT_EN
    check_eq("event_count", int'(event_count), m_count);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int n);
    detected     = 1'b1;
    switch_level = 1'b1;
    tick();
    detected = 1'b0;
    ticks(n - 1);
  endtask

  task automatic release_for(input int n);
    switch_level = 1'b0;
    ticks(n);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    detected     = 1'b0;
    switch_level = 1'b0;
    ticks(2);
    RST = 1'b0;
  endtask

  initial begin
    int k;
    int lvl_run;
    logic lvl_prev;
    RST          = 1'b1;
    detected     = 1'b0;
    switch_level = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("reset_single", int'(single_click), 0);
    check_eq("reset_double", int'(double_click), 0);
    check_eq("reset_long", int'(long_press), 0);
    check_eq("reset_busy", int'(busy), 0);
`ifdef PRESS_COUNT_EN
    check_eq("reset_count", int'(event_count), 0);
`endif
    RST = 1'b0;
    ticks(2);

    // Single click: latency counted from the release sample.
    press(5);
    switch_level = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!single_click && k < 40);
    check_eq("s1_single_latency", k, 11);
    ticks(3);
    check_eq("s1_busy_after", int'(busy), 0);

    // Double click.
    press(5);
    release_for(4);
    detected     = 1'b1;
    switch_level = 1'b1;
    tick();
    check_eq("s2_double_now", int'(double_click), 1);
    detected = 1'b0;
    ticks(3);
    release_for(15);
    check_eq("s2_idle", int'(busy), 0);

    // Long press with a stray detected while held.
    detected     = 1'b1;
    switch_level = 1'b1;
    k = 0;
    do begin
      tick();
      detected = 1'b0;
      k++;
    end while (!long_press && k < 40);
    check_eq("s3_long_latency", k, 21);
    ticks(4);
    detected = 1'b1;
    tick();
    detected = 1'b0;
    ticks(4);
    release_for(15);

    // Second press on the gap-timeout cycle.
    press(5);
    switch_level = 1'b0;
    ticks(10);
    detected     = 1'b1;
    switch_level = 1'b1;
    tick();
    check_eq("s4_double", int'(double_click), 1);
    check_eq("s4_no_single", int'(single_click), 0);
    detected = 1'b0;
    release_for(15);

    // Asynchronous reset mid-press, away from any clock edge.
    press(8);
    #2;
    RST = 1'b1;
    #1;
    check_eq("s5_busy_async", int'(busy), 0);
    check_eq("s5_single_async", int'(single_click), 0);
    check_eq("s5_long_async", int'(long_press), 0);
    model_reset();
    tick();
    RST = 1'b0;
    release_for(30);

    // Event counting and wrap.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(3);
      release_for(12);
    end
    press(3);
    release_for(2);
    press(2);
    release_for(2);
    press(22);
    release_for(2);
`ifdef PRESS_COUNT_EN
    check_eq("s6_count5", int'(event_count), 5);
`endif
    for (int i = 0; i < 256; i++) begin
      press(2);
      release_for(11);
    end
`ifdef PRESS_COUNT_EN
    check_eq("s6_count_wrap", int'(event_count), 5);
`endif

    // Randomized gestures with occasional stray pulses.
    lvl_prev = 1'b0;
    lvl_run  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (lvl_run == 0) begin
        switch_level = ~lvl_prev;
        lvl_run      = int'($urandom_range(1, 30));
      end
      lvl_run--;
      detected = (switch_level && !lvl_prev) || ($urandom_range(0, 49) == 0);
      lvl_prev = switch_level;
      tick();
    end
    detected = 1'b0;
    release_for(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
